// File: rtl/dma_axi_simple_chunk_sched.sv
// dma_axi_simple_chunk_sched
// Splits a CSR-programmed DMA job into 4 KB-safe read/write chunk commands.
module dma_axi_simple_chunk_sched #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    DMA_EN,
    input  logic                    DMA_GO,
    input  logic [AXI_WIDTH_AD-1:0] DMA_SRC,
    input  logic [AXI_WIDTH_AD-1:0] DMA_DST,
    input  logic [15:0]             DMA_BNUM,
    input  logic [7:0]              DMA_CHUNK,
    output logic                    DMA_BUSY,
    output logic                    DMA_DONE,
    output logic                    RD_REQ,
    input  logic                    RD_ACK,
    output logic [AXI_WIDTH_AD-1:0] RD_ADDR,
    output logic [8:0]              RD_BNUM,
    input  logic                    RD_DONE,
    output logic                    WR_REQ,
    input  logic                    WR_ACK,
    output logic [AXI_WIDTH_AD-1:0] WR_ADDR,
    output logic [8:0]              WR_BNUM,
    input  logic                    WR_DONE
);

    localparam int ALIGN_LSB = $clog2(AXI_WIDTH_DA / 8);
    localparam int PADW      = AXI_WIDTH_AD - 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    go_q;
    logic                    abort_q;
    logic [AXI_WIDTH_AD-1:0] src_q, dst_q;
    logic [15:0]             rem_q;
    logic [8:0]              chk_q;
    logic [8:0]              step_q;

    logic [AXI_WIDTH_AD-1:0] src_al, dst_al;
    logic [15:0]             bnum_al;
    logic [7:0]              chunk_al;
    logic [8:0]              chk_al;
    logic [12:0]             page_s, page_d;
    logic [8:0]              step_c;
    logic                    start;
    logic                    stop;

    assign start = (state_q == ST_IDLE) && DMA_GO && !go_q && DMA_EN;
    assign stop  = abort_q || !DMA_EN;

    // Word-align the CSR job fields; a zero chunk means a full 256 bytes.
    always_comb begin
        src_al   = (DMA_SRC >> ALIGN_LSB) << ALIGN_LSB;
        dst_al   = (DMA_DST >> ALIGN_LSB) << ALIGN_LSB;
        bnum_al  = (DMA_BNUM >> ALIGN_LSB) << ALIGN_LSB;
        chunk_al = (DMA_CHUNK >> ALIGN_LSB) << ALIGN_LSB;
        chk_al   = (chunk_al == 8'd0) ? 9'd256 : {1'b0, chunk_al};
    end

    // Step size: remaining bytes, chunk limit and both 4 KB page tails.
    always_comb begin
        page_s = 13'd4096 - {1'b0, src_q[11:0]};
        page_d = 13'd4096 - {1'b0, dst_q[11:0]};
        step_c = chk_q;
        if (page_s < {4'd0, step_c}) step_c = page_s[8:0];
        if (page_d < {4'd0, step_c}) step_c = page_d[8:0];
        if (rem_q < {7'd0, step_c})  step_c = rem_q[8:0];
    end

    // Sequencer next state; an abort lets an issued command finish first.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CALC;
            end
            ST_CALC: begin
                if (stop)                state_d = ST_IDLE;
                else if (rem_q == 16'd0) state_d = ST_DONE;
                else                     state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (RD_ACK) begin
                    if (!RD_DONE)  state_d = ST_RD_WAIT;
                    else if (stop) state_d = ST_IDLE;
                    else           state_d = ST_WR_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (RD_DONE) state_d = stop ? ST_IDLE : ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (WR_ACK) begin
                    if (!WR_DONE)  state_d = ST_WR_WAIT;
                    else if (stop) state_d = ST_IDLE;
                    else           state_d = ST_NEXT;
                end
            end
            ST_WR_WAIT: begin
                if (WR_DONE) state_d = stop ? ST_IDLE : ST_NEXT;
            end
            ST_NEXT: begin
                state_d = stop ? ST_IDLE : ST_CALC;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, GO edge detector and sticky abort flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            go_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= DMA_GO;
            abort_q <= (state_q != ST_IDLE) && stop;
        end
    end

    // Job registers: latched on start, stepped after each write completes.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            chk_q  <= '0;
            step_q <= '0;
        end else begin
            if (start) begin
                src_q <= src_al;
                dst_q <= dst_al;
                rem_q <= bnum_al;
                chk_q <= chk_al;
            end
            if (state_q == ST_CALC) step_q <= step_c;
            if (state_q == ST_NEXT) begin
                src_q <= src_q + {{PADW{1'b0}}, step_q};
                dst_q <= dst_q + {{PADW{1'b0}}, step_q};
                rem_q <= rem_q - {7'd0, step_q};
            end
        end
    end

    assign DMA_BUSY = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign DMA_DONE = (state_q == ST_DONE);
    assign RD_REQ   = (state_q == ST_RD_REQ);
    assign WR_REQ   = (state_q == ST_WR_REQ);
    assign RD_ADDR  = src_q;
    assign WR_ADDR  = dst_q;
    assign RD_BNUM  = step_q;
    assign WR_BNUM  = step_q;

endmodule

// File: tb/tb_dma_axi_simple_chunk_sched.sv
// tb_dma_axi_simple_chunk_sched
// Table, corner-case and random jobs checked against a chunking model.
module tb_dma_axi_simple_chunk_sched;

    logic        ACLK      = 1'b0;
    logic        ARESETn   = 1'b0;
    logic        DMA_EN    = 1'b0;
    logic        DMA_GO    = 1'b0;
    logic [31:0] DMA_SRC   = '0;
    logic [31:0] DMA_DST   = '0;
    logic [15:0] DMA_BNUM  = '0;
    logic [7:0]  DMA_CHUNK = '0;
    logic        DMA_BUSY, DMA_DONE;
    logic        RD_REQ, WR_REQ;
    logic        RD_ACK  = 1'b0, RD_DONE = 1'b0;
    logic        WR_ACK  = 1'b0, WR_DONE = 1'b0;
    logic [31:0] RD_ADDR, WR_ADDR;
    logic [8:0]  RD_BNUM, WR_BNUM;

    always #5 ACLK = ~ACLK;

    dma_axi_simple_chunk_sched #(
        .AXI_WIDTH_AD(32),
        .AXI_WIDTH_DA(32)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .DMA_EN(DMA_EN), .DMA_GO(DMA_GO),
        .DMA_SRC(DMA_SRC), .DMA_DST(DMA_DST),
        .DMA_BNUM(DMA_BNUM), .DMA_CHUNK(DMA_CHUNK),
        .DMA_BUSY(DMA_BUSY), .DMA_DONE(DMA_DONE),
        .RD_REQ(RD_REQ), .RD_ACK(RD_ACK), .RD_ADDR(RD_ADDR),
        .RD_BNUM(RD_BNUM), .RD_DONE(RD_DONE),
        .WR_REQ(WR_REQ), .WR_ACK(WR_ACK), .WR_ADDR(WR_ADDR),
        .WR_BNUM(WR_BNUM), .WR_DONE(WR_DONE)
    );

    typedef struct {
        logic [31:0] a;
        logic [8:0]  n;
    } cmd_t;

    typedef struct {
        int unsigned s;
        int unsigned d;
        int unsigned n;
    } step_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] bnum;
        logic [7:0]  chunk;
        int          nsteps;
        int          first_n;
        int          last_n;
        logic [31:0] last_src;
    } vec_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    cmd_t  rd_log[$];
    cmd_t  wr_log[$];
    step_t exp_q[$];
    vec_t  vecs[7];

    int done_cnt, done_cyc, viol, tviol, rd_done_given;
    int last_rdone, last_wdone;
    bit timed_out, req_seen;
    int rd_ack_dly, rd_dly, wr_ack_dly, wr_dly;
    bit rd_pend, wr_pend, drop_en, do_rst;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: greedy split honouring chunk size and 4 KB pages.
    task automatic build_model(input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] b, input logic [7:0] c);
        int unsigned src, dst, rem, chunk, step;
        exp_q.delete();
        src   = s & ~32'd3;
        dst   = d & ~32'd3;
        rem   = {16'd0, b} & ~32'd3;
        chunk = {24'd0, c} & ~32'd3;
        if (chunk == 0) chunk = 256;
        while (rem > 0) begin
            step = rem;
            if (chunk < step) step = chunk;
            if (32'd4096 - (src % 32'd4096) < step) step = 32'd4096 - (src % 32'd4096);
            if (32'd4096 - (dst % 32'd4096) < step) step = 32'd4096 - (dst % 32'd4096);
            exp_q.push_back('{src, dst, step});
            src += step;
            dst += step;
            rem -= step;
        end
    endtask

    task automatic apply_reset();
        ARESETn = 1'b0;
        DMA_GO  = 1'b0;
        RD_ACK  = 1'b0; RD_DONE = 1'b0;
        WR_ACK  = 1'b0; WR_DONE = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        rd_pend = 1'b0;
        wr_pend = 1'b0;
    endtask

    // Engine stand-ins with random accept/completion latency.
    task automatic drive_engines(input int cyc, input int mode);
        int d;
        RD_ACK = 1'b0; RD_DONE = 1'b0;
        WR_ACK = 1'b0; WR_DONE = 1'b0;
        if (drop_en) begin
            DMA_EN  = 1'b0;
            drop_en = 1'b0;
        end
        if (rd_pend) begin
            if (rd_dly == 0) begin
                RD_DONE = 1'b1; rd_pend = 1'b0;
                rd_done_given++; last_rdone = cyc;
            end else rd_dly--;
        end else if (RD_REQ) begin
            if (rd_ack_dly > 0) rd_ack_dly--;
            else begin
                RD_ACK = 1'b1;
                rd_log.push_back('{RD_ADDR, RD_BNUM});
                rd_ack_dly = $urandom_range(0, 2);
                d = $urandom_range(0, 3);
                if (mode == 1 && rd_log.size() == 1) begin
                    d = 3; drop_en = 1'b1;
                end
                if (d == 0) begin
                    RD_DONE = 1'b1; rd_done_given++; last_rdone = cyc;
                end else begin
                    rd_pend = 1'b1; rd_dly = d - 1;
                end
            end
        end
        if (wr_pend) begin
            if (wr_dly == 0) begin
                WR_DONE = 1'b1; wr_pend = 1'b0; last_wdone = cyc;
            end else wr_dly--;
        end else if (WR_REQ) begin
            if (wr_ack_dly > 0) wr_ack_dly--;
            else begin
                WR_ACK = 1'b1;
                wr_log.push_back('{WR_ADDR, WR_BNUM});
                wr_ack_dly = $urandom_range(0, 2);
                d = $urandom_range(0, 3);
                if (mode == 2 && wr_log.size() == 1) begin
                    d = 3; do_rst = 1'b1;
                end
                if (d == 0) begin
                    WR_DONE = 1'b1; last_wdone = cyc;
                end else begin
                    wr_pend = 1'b1; wr_dly = d - 1;
                end
            end
        end
    endtask

    // mode 0: normal, 1: EN drop in first RD_WAIT, 2: reset in first WR_WAIT.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] b, input logic [7:0] c,
                           input int mode);
        int   cyc;
        int   exp_t;
        bit   p_rreq, p_rack, p_wreq, p_wack;
        cmd_t p_r, p_w;
        rd_log.delete(); wr_log.delete();
        done_cnt = 0; done_cyc = -1; viol = 0; tviol = 0;
        rd_done_given = 0; timed_out = 1'b0; req_seen = 1'b0;
        last_rdone = -100; last_wdone = -100;
        rd_pend = 1'b0; wr_pend = 1'b0; drop_en = 1'b0; do_rst = 1'b0;
        rd_ack_dly = $urandom_range(0, 2);
        wr_ack_dly = $urandom_range(0, 2);
        p_rreq = 1'b0; p_rack = 1'b0; p_wreq = 1'b0; p_wack = 1'b0;
        p_r = '{32'd0, 9'd0}; p_w = '{32'd0, 9'd0};
        @(negedge ACLK);
        DMA_SRC = s; DMA_DST = d; DMA_BNUM = b; DMA_CHUNK = c;
        DMA_EN = 1'b1; DMA_GO = 1'b1;
        for (cyc = 1; cyc <= 20000; cyc++) begin
            @(negedge ACLK);
            if (cyc == 1) DMA_GO = 1'b0;
            if (cyc == 3 && DMA_BUSY) DMA_GO = 1'b1;
            if (cyc == 4) DMA_GO = 1'b0;
            if (do_rst) begin
                check("state before reset", {DMA_BUSY, RD_REQ, WR_REQ}, 3'b100);
                #2 ARESETn = 1'b0;
                #1;
                check("async reset flags", {DMA_BUSY, DMA_DONE, RD_REQ, WR_REQ}, 0);
                check("async reset addrs", RD_ADDR | WR_ADDR, 0);
                check("async reset bnums", {RD_BNUM, WR_BNUM}, 0);
                apply_reset();
                return;
            end
            if (DMA_DONE) begin
                done_cnt++; done_cyc = cyc;
                exp_t = (wr_log.size() == 0) ? 2 : last_wdone + 3;
                if (cyc != exp_t || DMA_BUSY) tviol++;
            end
            if (RD_REQ || WR_REQ) req_seen = 1'b1;
            if ((RD_REQ || WR_REQ) && !DMA_BUSY) viol++;
            if (RD_REQ && WR_REQ) viol++;
            if (p_rreq && !p_rack && (!RD_REQ || RD_ADDR != p_r.a || RD_BNUM != p_r.n)) viol++;
            if (p_wreq && !p_wack && (!WR_REQ || WR_ADDR != p_w.a || WR_BNUM != p_w.n)) viol++;
            if (p_rack && RD_REQ) viol++;
            if (p_wack && WR_REQ) viol++;
            if (RD_REQ && !p_rreq) begin
                exp_t = (wr_log.size() == 0) ? 2 : last_wdone + 3;
                if (cyc != exp_t) tviol++;
            end
            if (WR_REQ && !p_wreq && cyc != last_rdone + 1) tviol++;
            if (cyc >= 2 && !DMA_BUSY) break;
            p_rreq = RD_REQ; p_wreq = WR_REQ;
            p_r = '{RD_ADDR, RD_BNUM}; p_w = '{WR_ADDR, WR_BNUM};
            drive_engines(cyc, mode);
            p_rack = RD_ACK; p_wack = WR_ACK;
        end
        RD_ACK = 1'b0; RD_DONE = 1'b0; WR_ACK = 1'b0; WR_DONE = 1'b0;
        if (cyc > 20000) begin
            timed_out = 1'b1;
            apply_reset();
        end
        repeat (3) begin
            @(negedge ACLK);
            if (DMA_DONE || DMA_BUSY || RD_REQ || WR_REQ) viol++;
        end
    endtask

    task automatic post_checks(input string tag, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] b, input logic [7:0] c);
        int bad_r, bad_w;
        build_model(s, d, b, c);
        check({tag, " timeout"}, timed_out, 0);
        check({tag, " rd count"}, rd_log.size(), exp_q.size());
        check({tag, " wr count"}, wr_log.size(), exp_q.size());
        bad_r = 0; bad_w = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rd_log.size())
                if (rd_log[i].a != exp_q[i].s || {23'd0, rd_log[i].n} != exp_q[i].n) bad_r++;
            if (i < wr_log.size())
                if (wr_log[i].a != exp_q[i].d || {23'd0, wr_log[i].n} != exp_q[i].n) bad_w++;
        end
        check({tag, " rd cmd mismatches"}, bad_r, 0);
        check({tag, " wr cmd mismatches"}, bad_w, 0);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " protocol errors"}, viol, 0);
        check({tag, " timing errors"}, tviol, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs, rdst;
        logic [15:0] rb;
        logic [7:0]  rc;
        bit          seen;

        vecs[0] = '{32'h1000, 32'h2000, 16'd64,    8'd16,   4, 16,  16,  32'h1030};
        vecs[1] = '{32'h0FF8, 32'h3000, 16'd32,    8'd32,   2, 8,   24,  32'h1000};
        vecs[2] = '{32'h0000, 32'h0100, 16'd40,    8'd16,   3, 16,  8,   32'h0020};
        vecs[3] = '{32'h0000, 32'h0000, 16'h0300,  8'd0,    3, 256, 256, 32'h0200};
        vecs[4] = '{32'h1003, 32'h2001, 16'h0043,  8'h13,   4, 16,  16,  32'h1030};
        vecs[5] = '{32'h0FFC, 32'h1FF0, 16'h0100,  8'h80,   4, 4,   112, 32'h108C};
        vecs[6] = '{32'h0040, 32'h0080, 16'd3,     8'd8,    0, 0,   0,   32'h0000};

        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("reset flags", {DMA_BUSY, DMA_DONE, RD_REQ, WR_REQ}, 0);
        check("reset addrs", RD_ADDR | WR_ADDR, 0);
        check("reset bnums", {RD_BNUM, WR_BNUM}, 0);

        DMA_EN = 1'b0; DMA_SRC = 32'h1000; DMA_DST = 32'h2000;
        DMA_BNUM = 16'd64; DMA_CHUNK = 8'd16; DMA_GO = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge ACLK);
            seen |= DMA_BUSY | DMA_DONE | RD_REQ | WR_REQ;
        end
        check("GO with EN=0 ignored", seen, 0);
        DMA_GO = 1'b0;
        @(negedge ACLK);

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].src, vecs[i].dst, vecs[i].bnum, vecs[i].chunk, 0);
            check($sformatf("vec%0d steps", i), rd_log.size(), vecs[i].nsteps);
            if (rd_log.size() > 0 && vecs[i].nsteps > 0) begin
                check($sformatf("vec%0d first bnum", i), rd_log[0].n, vecs[i].first_n);
                check($sformatf("vec%0d last bnum", i), rd_log[rd_log.size()-1].n, vecs[i].last_n);
                check($sformatf("vec%0d last src", i), rd_log[rd_log.size()-1].a, vecs[i].last_src);
            end
            post_checks($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst,
                        vecs[i].bnum, vecs[i].chunk);
        end

        run_job(32'h0100, 32'h0200, 16'd0, 8'd4, 0);
        check("zero job done cycle", done_cyc, 2);
        check("zero job req seen", req_seen, 0);
        check("zero job done pulses", done_cnt, 1);

        run_job(32'h1000, 32'h2000, 16'd64, 8'd16, 1);
        check("abort timeout", timed_out, 0);
        check("abort rd count", rd_log.size(), 1);
        if (rd_log.size() > 0) begin
            check("abort rd addr", rd_log[0].a, 32'h1000);
            check("abort rd bnum", rd_log[0].n, 16);
        end
        check("abort rd done delivered", rd_done_given, 1);
        check("abort wr count", wr_log.size(), 0);
        check("abort done pulses", done_cnt, 0);
        check("abort protocol errors", viol, 0);

        run_job(32'h1000, 32'h2000, 16'd64, 8'd16, 2);
        run_job(32'h5FF0, 32'h7000, 16'd48, 8'd0, 0);
        check("post-reset first bnum", (rd_log.size() > 0) ? rd_log[0].n : 9'd0, 16);
        post_checks("post-reset", 32'h5FF0, 32'h7000, 16'd48, 8'd0);

        for (int j = 0; j < 25; j++) begin
            rs   = $urandom;
            rdst = $urandom;
            if ($urandom_range(0, 1) == 1) rs[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
            if ($urandom_range(0, 1) == 1) rdst[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
            rb = 16'($urandom_range(0, 512));
            rc = 8'($urandom);
            run_job(rs, rdst, rb, rc, 0);
            post_checks($sformatf("rand%0d", j), rs, rdst, rb, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dma_axi_simple_chunk_sched.md
# dma_axi_simple_chunk_sched

Transfer scheduler for the simple AXI DMA. It takes the CSR-programmed job (source, destination, byte count, chunk size) and splits it into read/write chunk commands. It issues those commands to the AXI read engine and AXI write engine through request/acknowledge handshakes, and reports BUSY/DONE back to the CSR block. It sits between the CSR slave and the two AXI master engines, and is the only block that sequences the datapath.

## Interface
- AXI_WIDTH_AD, 32, address width of SRC/DST and engine command addresses
- AXI_WIDTH_DA, 32, data width; only 32 is supported, so steps are word multiples
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- DMA_EN  in  1  engine enable from CSR
- DMA_GO  in  1  start level from CSR; the rising edge starts a job
- DMA_SRC  in  32  source byte address; bits [1:0] are ignored (treated as 0)
- DMA_DST  in  32  destination byte address; bits [1:0] are ignored
- DMA_BNUM  in  16  total bytes to move; bits [1:0] are ignored
- DMA_CHUNK  in  8  max bytes per step; 0 means 256; bits [1:0] are ignored, and a resulting 4..252 value is used as is
- DMA_BUSY  out  1  job in progress
- DMA_DONE  out  1  one-cycle pulse on normal job completion
- RD_REQ  out  1  read command valid
- RD_ACK  in  1  read engine accepts command
- RD_ADDR  out  32  read command start address
- RD_BNUM  out  9  read command byte count (4..256)
- RD_DONE  in  1  pulse: read data for the command is in the buffer
- WR_REQ / WR_ACK / WR_ADDR / WR_BNUM / WR_DONE: same as RD_*, for the write engine; WR_DONE means BRESP has been received

## Operation
- States: IDLE, CALC, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, DONE.
- IDLE: a rising edge of DMA_GO (registered copy 0, input 1) with DMA_EN=1 latches the job.
  - Latched values: src=SRC&~3, dst=DST&~3, rem=BNUM&~3, chk=(CHUNK&~3) or 256 if that is 0.
  - Then go to CALC. A GO edge with DMA_EN=0 is ignored.
- CALC: if rem==0, go to DONE. Otherwise compute step, then go to RD_REQ.
  - step = min(rem, chk, 4096-src[11:0], 4096-dst[11:0]).
  - Arithmetic is unsigned, 13 bits wide. Step never crosses a 4 KB boundary on either side.
- RD_REQ: RD_REQ=1 with RD_ADDR=src, RD_BNUM=step.
  - On RD_ACK, go to RD_WAIT.
  - If RD_ACK and RD_DONE arrive in the same cycle, go straight to WR_REQ.
- RD_WAIT: on RD_DONE, go to WR_REQ.
- WR_REQ / WR_WAIT: same pattern as the read states, with WR_ADDR=dst and WR_BNUM=step. On WR_DONE, go to NEXT.
- NEXT: src+=step, dst+=step, rem-=step (32-bit wrap, no saturation). Then go to CALC.
- DONE: DMA_DONE=1 for one cycle, then go to IDLE.
- Abort when DMA_EN=0 while not in IDLE:
  - No new command is issued.
  - An already-raised REQ is held until ACK, and the matching DONE is awaited. That command still completes.
  - Then go to IDLE with no DMA_DONE pulse.
  - If already in CALC or NEXT, go to IDLE at once.
- GO edges while not in IDLE are ignored. CSR changes during a job have no effect until the next start.
- DONE/ACK pulses that arrive in a state not waiting for them are ignored.

## Timing
- Reset values: state=IDLE, DMA_BUSY=0, DMA_DONE=0, RD_REQ=0, WR_REQ=0, RD_ADDR=0, WR_ADDR=0, RD_BNUM=0, WR_BNUM=0, GO edge register=0.
- All outputs are registered or decoded from registered state. There is no combinational path from input to output.
- GO edge in cycle N gives CALC in N+1 and RD_REQ=1 in N+2.
- DMA_BUSY=1 in every state except IDLE and DONE.
- REQ is held stable, along with ADDR and BNUM, until the cycle ACK is sampled high. REQ is 0 in the following cycle.
- WR_DONE in cycle M leads to NEXT in M+1 and CALC in M+2.
  - If that was the last step, DONE (DMA_DONE=1, DMA_BUSY=0) is in M+3.
  - Otherwise the next RD_REQ is in M+3.
- Per-step overhead is 4 cycles plus engine latency. Read and write never overlap.
- BNUM<4 (a zero job): DMA_DONE in N+2, with no REQ issued.
- ARESETn low at any time returns all registers to reset values immediately. Engines must drop their own state on the same reset.

## Test plan
- SRC=0x1000, DST=0x2000, BNUM=64, CHUNK=16: expect four read/write pairs at 0x1000/0x2000 … 0x1030/0x2030, each 16 bytes. Expect exactly one DMA_DONE, and BUSY low afterwards.
- SRC=0x0FF8, DST=0x3000, BNUM=32, CHUNK=32: expect step 1 to be 8 bytes (0x0FF8→0x3000) and step 2 to be 24 bytes (0x1000→0x3008). No command crosses 4 KB.
- BNUM=40, CHUNK=16: expect steps of 16, 16, 8. With CHUNK=0 and BNUM=0x0300: expect three 256-byte steps.
- BNUM=0: expect DMA_DONE exactly 2 cycles after the GO edge, with RD_REQ and WR_REQ never asserted. A second GO edge while BUSY is ignored.
- DMA_EN dropped during RD_WAIT of step 1 (of 4): expect the read to complete and no WR_REQ. Expect return to IDLE with BUSY=0 and no DMA_DONE.
- ARESETn asserted during WR_WAIT: all outputs go to 0 at once. After release, a new GO starts cleanly from the new CSR values.
